// File: rtl/aes_pkg.sv
// Shared AES definitions: sizes, round-constant values, FSM state type and the
// GF(2^8) xtime helper used by the key schedule.
package aes_pkg;

    localparam int unsigned AES_WORD  = 8;   // bits per byte
    localparam int unsigned AES_BYTES = 16;  // bytes per state / key
    localparam int unsigned AES_NR    = 10;  // rounds for AES-128
    localparam int unsigned AES_IDX_W = 4;   // round-index width

    localparam logic [7:0] AES_RCON_INIT = 8'h01;
    localparam logic [7:0] AES_RED_POLY  = 8'h1B;  // x^8 reduction (x^4+x^3+x+1)

    typedef enum logic {
        IDLE,
        RUN
    } aes_state_e;

    // Multiply by x in GF(2^8).
    function automatic logic [7:0] aes_xtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? AES_RED_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box.
// Ports:
//   data_i - input byte
//   data_o - substituted byte
module aes_sbox (
    input  logic [7:0] data_i,
    output logic [7:0] data_o
);

    // Byte n of the table sits at bits [2047-8n -: 8].
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] bit_hi;

    assign bit_hi = 11'd2047 - {data_i, 3'b000};
    assign data_o = SBOX_TBL[bit_hi -: 8];

endmodule

// File: rtl/aes_key_expand_seq.sv
// Sequential AES-128 key schedule. Emits round keys 0..NR one per ready/valid
// handshake; round 0 is the cipher key itself.
// Optional feature: define AES_KEY_STORE_EN to keep every accepted round key in
// an (NR+1)-entry register file readable through rd_idx/rd_key.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   start, key_in     - load a cipher key (ignored while busy)
//   rk_ready          - consumer accepts rk_out this cycle
//   rk_valid, rk_out  - current round key and its validity
//   rk_idx            - round index of rk_out
//   busy              - schedule in progress
//   done              - one-cycle pulse after the last key is accepted
//   rd_idx, rd_key    - stored-key read port (AES_KEY_STORE_EN only)
module aes_key_expand_seq
    import aes_pkg::*;
#(
    parameter int unsigned word_size  = AES_WORD,
    parameter int unsigned array_size = AES_BYTES,
    parameter int unsigned NR         = AES_NR
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [word_size*array_size-1:0] key_in,
    input  logic                            rk_ready,
    output logic                            rk_valid,
    output logic [word_size*array_size-1:0] rk_out,
    output logic [AES_IDX_W-1:0]            rk_idx,
    output logic                            busy,
    output logic                            done
`ifdef AES_KEY_STORE_EN
    ,
    input  logic [AES_IDX_W-1:0]            rd_idx,
    output logic [word_size*array_size-1:0] rd_key
`endif
);

    localparam int unsigned KeyW = word_size * array_size;
    localparam logic [AES_IDX_W-1:0] LastIdx = AES_IDX_W'(NR);

    if (array_size != 16 || word_size != 8) begin : g_bad_cfg
        $error("aes_key_expand_seq supports AES-128 only (8-bit words, 16 bytes)");
    end

    aes_state_e           state_q, state_d;
    logic [KeyW-1:0]      rk_out_q, rk_out_d;
    logic [AES_IDX_W-1:0] rk_idx_q, rk_idx_d;
    logic [7:0]           rcon_q, rcon_d;
    logic                 rk_valid_q, rk_valid_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 accept;

    // next_key datapath: t = SubWord(RotWord(w3)) ^ {rcon, 24'h0}
    logic [31:0] rot_w, sub_w, t_w;
    logic [31:0] nw0, nw1, nw2, nw3;

    assign rot_w = {rk_out_q[23:0], rk_out_q[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .data_i (rot_w[8*b +: 8]),
            .data_o (sub_w[8*b +: 8])
        );
    end

    always_comb begin
        t_w = sub_w ^ {rcon_q, 24'h0};
        nw0 = rk_out_q[127:96] ^ t_w;
        nw1 = rk_out_q[95:64]  ^ nw0;
        nw2 = rk_out_q[63:32]  ^ nw1;
        nw3 = rk_out_q[31:0]   ^ nw2;
    end

    assign accept = (state_q == RUN) && rk_valid_q && rk_ready;

    always_comb begin
        state_d    = state_q;
        rk_out_d   = rk_out_q;
        rk_idx_d   = rk_idx_q;
        rcon_d     = rcon_q;
        rk_valid_d = rk_valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    rk_out_d   = key_in;
                    rk_idx_d   = '0;
                    rcon_d     = AES_RCON_INIT;
                    rk_valid_d = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = RUN;
                end
            end
            RUN: begin
                // start is deliberately not looked at here: no restart mid-schedule.
                if (accept) begin
                    if (rk_idx_q == LastIdx) begin
                        rk_valid_d = 1'b0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        rk_out_d = {nw0, nw1, nw2, nw3};
                        rk_idx_d = rk_idx_q + 4'd1;
                        rcon_d   = aes_xtime(rcon_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rk_out_q   <= '0;
            rk_idx_q   <= '0;
            rcon_q     <= AES_RCON_INIT;
            rk_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rk_out_q   <= rk_out_d;
            rk_idx_q   <= rk_idx_d;
            rcon_q     <= rcon_d;
            rk_valid_q <= rk_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign rk_valid = rk_valid_q;
    assign rk_out   = rk_out_q;
    assign rk_idx   = rk_idx_q;
    assign busy     = busy_q;
    assign done     = done_q;

`ifdef AES_KEY_STORE_EN
    // Keys survive start so a decryption engine can walk them in reverse order.
    logic [KeyW-1:0] store_q [NR+1];
    logic [KeyW-1:0] store_d [NR+1];
    logic [KeyW-1:0] rd_key_q, rd_key_d;

    always_comb begin
        store_d = store_q;
        if (accept) begin
            store_d[rk_idx_q] = rk_out_q;
        end
        rd_key_d = '0;
        if (rd_idx <= LastIdx) begin
            rd_key_d = store_q[rd_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            store_q  <= '{default: '0};
            rd_key_q <= '0;
        end else begin
            store_q  <= store_d;
            rd_key_q <= rd_key_d;
        end
    end

    assign rd_key = rd_key_q;
`endif

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Self-checking bench for aes_key_expand_seq. The reference computes the S-box
// from GF(2^8) inversion plus the affine map and expands keys word by word.
module tb_aes_key_expand_seq;
    localparam int NR = 10;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [127:0] key_in;
    logic         rk_ready;
    logic         rk_valid;
    logic [127:0] rk_out;
    logic [3:0]   rk_idx;
    logic         busy;
    logic         done;
`ifdef AES_KEY_STORE_EN
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;
`endif

    aes_key_expand_seq u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .key_in   (key_in),
        .rk_ready (rk_ready),
        .rk_valid (rk_valid),
        .rk_out   (rk_out),
        .rk_idx   (rk_idx),
        .busy     (busy),
`ifdef AES_KEY_STORE_EN
        .done     (done),
        .rd_idx   (rd_idx),
        .rd_key   (rd_key)
`else
        .done     (done)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    logic [7:0]   sb       [256];
    logic [127:0] exp_keys [11];
    logic [127:0] got_keys [11];

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d;
        d = {v, v} << n;
        return d[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Textbook word-wise AES-128 expansion into exp_keys[0..10].
    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  r;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        r = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {r, 24'h0};
                r = gf_mul(r, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int k = 0; k <= NR; k++) exp_keys[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    endtask

    // mode 0: ready=1, extra start at final acceptance
    // mode 1: random ready with a 5-cycle stall at idx 3
    // mode 2: spurious start at idx 4
    // mode 3: reset at idx 6
    task automatic run_schedule(input logic [127:0] key, input int mode);
        int idx, stall, cycles;
        bit aborted;
        expand_key(key);
        idx = 0; stall = 0; cycles = 0; aborted = 0;
        start = 1'b1;
        key_in = key;
        rk_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check_eq("busy_after_start", busy, 1);
        while (idx <= NR) begin
            if (cycles >= 400) begin
                check_eq("schedule_timeout_idx", idx, NR + 1);
                aborted = 1;
                break;
            end
            cycles++;
            check_eq($sformatf("valid_%0d", idx), rk_valid, 1);
            check_eq($sformatf("idx_%0d", idx), rk_idx, idx);
            check_eq($sformatf("key_%0d", idx), rk_out, exp_keys[idx]);
            if (mode == 3 && idx == 6) begin
                rst_n = 1'b0;
                #1;
                check_eq("async_reset_key", rk_out, 0);
                check_eq("async_reset_ctl", {rk_valid, busy, done, rk_idx}, 0);
                @(negedge clk);
                rst_n = 1'b1;
                aborted = 1;
                break;
            end
            if (mode == 2 && idx == 4) begin
                start = 1'b1;
                key_in = ~key;
            end
            if (mode == 0 && idx == NR) begin
                start = 1'b1;
                key_in = key ^ 128'h1;
            end
            if (mode == 1) begin
                if (idx == 3) begin
                    rk_ready = (stall >= 5);
                    stall++;
                end else begin
                    rk_ready = 1'($urandom_range(0, 1));
                end
            end else begin
                rk_ready = 1'b1;
            end
            if (rk_ready) got_keys[idx] = rk_out;
            @(negedge clk);
            start = 1'b0;
            if (rk_ready) idx++;
        end
        rk_ready = 1'b0;
        if (!aborted) begin
            check_eq("done_pulse", done, 1);
            check_eq("busy_low_at_done", busy, 0);
            check_eq("valid_low_at_done", rk_valid, 0);
            @(negedge clk);
            check_eq("done_one_cycle", done, 0);
            check_eq("idle_valid_low", rk_valid, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] k;
        rst_n    = 1'b1;
        start    = 1'b0;
        key_in   = '0;
        rk_ready = 1'b0;
`ifdef AES_KEY_STORE_EN
        rd_idx   = '0;
`endif
        build_sbox();
        #1 rst_n = 1'b0;
        #1;
        check_eq("reset_key", rk_out, 0);
        check_eq("reset_ctl", {rk_valid, busy, done, rk_idx}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // FIPS-197 A.1
        run_schedule(128'h2b7e151628aed2a6abf7158809cf4f3c, 0);
        check_eq("a1_idx0", got_keys[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
        check_eq("a1_idx1", got_keys[1], 128'ha0fafe1788542cb123a339392a6c7605);
        check_eq("a1_idx10", got_keys[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
`ifdef AES_KEY_STORE_EN
        rd_idx = 4'd10;
        @(negedge clk);
        check_eq("store_rd10", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        rd_idx = 4'd0;
        @(negedge clk);
        check_eq("store_rd0", rd_key, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        rd_idx = 4'd12;
        @(negedge clk);
        check_eq("store_rd12", rd_key, 0);
`endif

        run_schedule(128'h0, 0);
        check_eq("zero_idx1", got_keys[1], 128'h62636363626363636263636362636363);
        check_eq("zero_idx10", got_keys[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        for (int r = 0; r < 2; r++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            run_schedule(k, 1);
        end
        k = {$urandom, $urandom, $urandom, $urandom};
        run_schedule(k, 2);
        k = {$urandom, $urandom, $urandom, $urandom};
        run_schedule(k, 3);
        @(negedge clk);
        k = {$urandom, $urandom, $urandom, $urandom};
        run_schedule(k, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
